id_stage_pipe: RTL
==================

Name: id_stage_pipe

Overview:
- Pipelined successor to the single-cycle decode stage.
- Contains:
  - a parametrised register file with NREG entries, x0 hard-wired to zero;
  - the immediate extender;
  - the write-back select mux;
  - an ID/EX output register with valid/ready handshake, load-use stall detection and flush.
- Sits between the IF/ID register and EX; the write-back port comes from the WB stage.

Parameters:
- XLEN, 32, datapath width; immediates sign-extend to XLEN; legal values are 32 or 64.
- NREG, 32, number of architectural registers; 16 gives RV32E, 32 gives RV32I; register index ports are 5 bits wide regardless.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  IF/ID holds a valid instruction
- in_ready  out  1  stage accepts the instruction this cycle
- inst  in  32  instruction word
- pc  in  XLEN  instruction PC
- pc4  in  XLEN  PC+4
- sext_op  in  3  immediate format: 0=I, 1=S, 2=B, 3=U, 4=J, other=zero
- rf_we  in  1  decoded register write enable, travels with instruction
- rf_wsel  in  2  decoded write-back select, travels with instruction
- ex_is_load  in  1  instruction now in EX is a valid load
- ex_rd  in  5  destination register of that instruction
- flush  in  1  kill the contents of this stage, e.g. branch taken
- wb_we  in  1  write-back enable
- wb_wR  in  5  write-back destination
- wb_wsel  in  2  write-back select: 0=ALU, 1=EXT, 2=PC4, 3=MEM
- wb_aluc, wb_ext, wb_pc4, wb_mem  in  XLEN each  write-back candidate values
- out_valid  out  1  ID/EX holds a valid instruction
- out_ready  in  1  EX accepts ID/EX contents
- rD1, rD2  out  XLEN each  registered source operands
- ext  out  XLEN  registered immediate
- pc_out, pc4_out  out  XLEN each  registered PC and PC+4
- rd_out  out  5  registered inst[11:7]
- rf_we_out  out  1  registered rf_we
- rf_wsel_out  out  2  registered rf_wsel

Behaviour:
- Reset (rst_n=0): all registered outputs are 0, out_valid=0, all register-file entries are 0. Reset takes effect immediately, including mid-transfer.
- Register-file write: on a clk edge when wb_we=1, wb_wR!=0 and wb_wR<NREG, the entry takes the wsel-muxed value. Any other write request is ignored.
- Register-file read: rs1=inst[19:15], rs2=inst[24:20]. Index 0, or any index >= NREG, reads 0.
- Immediate extension:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - All formats sign-extend from inst[31] to XLEN.
- Hazard: hazard = ex_is_load & (ex_rd!=0) & (ex_rd==rs1 | ex_rd==rs2).
- Handshake:
  - stage_free = !out_valid | out_ready.
  - in_ready = stage_free & !hazard & !flush.
- Transfer: when in_valid & in_ready, on the next edge ID/EX captures all outputs and out_valid=1. Latency is one cycle.
- Bubble: when stage_free & !(in_valid & in_ready), out_valid goes to 0. Payload registers may hold stale data.
- Stall: when out_valid & !out_ready, every ID/EX register holds its value.
- Flush:
  - Forces out_valid=0 on the next edge and blocks capture.
  - flush takes priority over every other event.
  - Register-file writes proceed normally during a flush.
- Simultaneous events: stall and hazard together means hold. Flush and stall together means out_valid still clears.
- No read/write bypass unless the optional feature below is compiled in.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined: if wb_we=1 and wb_wR equals a nonzero, in-range source index in the same cycle, the captured rD1/rD2 take the incoming write-back value (write-through).
- Undefined: the captured value is the pre-write register contents, and the WB stage must avoid the hazard.

Test Plan:
- Reset: hold rst_n=0 with out_ready=1, in_valid=1 -> out_valid=0, rD1=rD2=0. After release, reading x5 gives 0.
- Write then read: WB writes x5=0x12345678 with wsel=0; next cycle in_valid with rs1=5 -> one cycle later rD1=0x12345678 and out_valid=1. Writing x0=0xFFFFFFFF -> x0 still reads 0.
- Immediates:
  - inst=0xFFF00093 with sext_op=0 -> ext=0xFFFFFFFF.
  - J-format inst=0x0080006F with sext_op=4 -> ext=0x00000008.
- Load-use: ex_is_load=1, ex_rd=3, rs2=3 -> in_ready=0. With out_ready=1, out_valid=0 next cycle. When ex_is_load drops, the instruction is captured.
- Backpressure and flush:
  - out_ready=0 for 3 cycles -> outputs held constant.
  - flush=1 while out_valid=1 -> out_valid=0 next edge and in_ready=0 during flush.
- Bypass: same-cycle write x7=0xA5A5A5A5 and read rs1=7 -> rD1=0xA5A5A5A5 with ID_WB_BYPASS_EN, old value without it.
- NREG=16: write x20 -> ignored; reading rs1=20 gives 0.

Source files
------------

// File: rtl/id_stage_pipe_if.sv
// Decode-stage handshake bundle: IF/ID input channel and ID/EX
// output channel, each with valid/ready.
interface id_stage_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc4;
  logic [2:0]      sext_op;
  logic            rf_we;
  logic [1:0]      rf_wsel;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] rD1;
  logic [XLEN-1:0] rD2;
  logic [XLEN-1:0] ext;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc4_out;
  logic [4:0]      rd_out;
  logic            rf_we_out;
  logic [1:0]      rf_wsel_out;

  modport master (
    output in_valid, inst, pc, pc4, sext_op, rf_we, rf_wsel,
    output out_ready,
    input  in_ready,
    input  out_valid, rD1, rD2, ext, pc_out, pc4_out,
    input  rd_out, rf_we_out, rf_wsel_out
  );

  modport slave (
    input  in_valid, inst, pc, pc4, sext_op, rf_we, rf_wsel,
    input  out_ready,
    output in_ready,
    output out_valid, rD1, rD2, ext, pc_out, pc4_out,
    output rd_out, rf_we_out, rf_wsel_out
  );
endinterface

// File: rtl/id_stage_pipe.sv
// Pipelined decode: regfile, immediate extender, WB mux, ID/EX register.
// Optional macro ID_WB_BYPASS_EN: write-through of WB value to rD1/rD2.
module id_stage_pipe #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  id_stage_pipe_if.slave  io,
  input  logic            ex_is_load,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_wR,
  input  logic [1:0]      wb_wsel,
  input  logic [XLEN-1:0] wb_aluc,
  input  logic [XLEN-1:0] wb_ext,
  input  logic [XLEN-1:0] wb_pc4,
  input  logic [XLEN-1:0] wb_mem
);
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [5:0] NLIM = 6'(NREG);

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] ext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [4:0]      rd;
    logic            we;
    logic [1:0]      wsel;
  } id_ex_t;

  logic [XLEN-1:0] rf [NREG];
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            rs1_ok;
  logic            rs2_ok;
  logic            wr_ok;
  logic [XLEN-1:0] wb_val;
  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;
  logic            hazard;
  logic            stage_free;
  logic            take;
  logic            valid;
  id_ex_t          q;
  id_ex_t          d;

  assign rs1 = io.inst[19:15];
  assign rs2 = io.inst[24:20];

  assign rs1_ok = (rs1 != 5'd0) && ({1'b0, rs1} < NLIM);
  assign rs2_ok = (rs2 != 5'd0) && ({1'b0, rs2} < NLIM);
  assign wr_ok  = wb_we && (wb_wR != 5'd0) && ({1'b0, wb_wR} < NLIM);

  // Write-back candidate select
  always_comb begin
    wb_val = wb_mem;
    unique case (1'b1)
      (wb_wsel == 2'd0): wb_val = wb_aluc;
      (wb_wsel == 2'd1): wb_val = wb_ext;
      (wb_wsel == 2'd2): wb_val = wb_pc4;
      default:           wb_val = wb_mem;
    endcase
  end

  // Register file; x0 and out-of-range writes are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wr_ok) begin
      rf[wb_wR[IW-1:0]] <= wb_val;
    end
  end

  assign rf_rd1 = rs1_ok ? rf[rs1[IW-1:0]] : '0;
  assign rf_rd2 = rs2_ok ? rf[rs2[IW-1:0]] : '0;

`ifdef ID_WB_BYPASS_EN
  assign rd1 = (wr_ok && wb_wR == rs1) ? wb_val : rf_rd1;
  assign rd2 = (wr_ok && wb_wR == rs2) ? wb_val : rf_rd2;
`else
  assign rd1 = rf_rd1;
  assign rd2 = rf_rd2;
`endif

  // Immediate assembly, sign-extended from inst[31]
  always_comb begin
    imm32 = '0;
    unique case (1'b1)
      (io.sext_op == 3'd0):
        imm32 = {{20{io.inst[31]}}, io.inst[31:20]};
      (io.sext_op == 3'd1):
        imm32 = {{20{io.inst[31]}}, io.inst[31:25],
                 io.inst[11:7]};
      (io.sext_op == 3'd2):
        imm32 = {{19{io.inst[31]}}, io.inst[31], io.inst[7],
                 io.inst[30:25], io.inst[11:8], 1'b0};
      (io.sext_op == 3'd3):
        imm32 = {io.inst[31:12], 12'b0};
      (io.sext_op == 3'd4):
        imm32 = {{11{io.inst[31]}}, io.inst[31], io.inst[19:12],
                 io.inst[20], io.inst[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  if (XLEN > 32) begin : g_wide
    assign imm = {{(XLEN-32){imm32[31]}}, imm32};
  end else begin : g_narrow
    assign imm = imm32;
  end

  assign hazard = ex_is_load && (ex_rd != 5'd0) &&
                  ((ex_rd == rs1) || (ex_rd == rs2));
  assign stage_free  = !valid || io.out_ready;
  assign io.in_ready = stage_free && !hazard && !flush;
  assign take        = io.in_valid && io.in_ready;

  assign d.rd1  = rd1;
  assign d.rd2  = rd2;
  assign d.ext  = imm;
  assign d.pc   = io.pc;
  assign d.pc4  = io.pc4;
  assign d.rd   = io.inst[11:7];
  assign d.we   = io.rf_we;
  assign d.wsel = io.rf_wsel;

  // ID/EX register: flush clears, stall holds, free slot loads or bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (stage_free) begin
      valid <= take;
      if (take) q <= d;
    end
  end

  assign io.out_valid   = valid;
  assign io.rD1         = q.rd1;
  assign io.rD2         = q.rd2;
  assign io.ext         = q.ext;
  assign io.pc_out      = q.pc;
  assign io.pc4_out     = q.pc4;
  assign io.rd_out      = q.rd;
  assign io.rf_we_out   = q.we;
  assign io.rf_wsel_out = q.wsel;
endmodule
